// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and default data-memory window for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_e;

    localparam logic [31:0] DM_BASE_DEF = 32'h6600_0000;
    localparam logic [31:0] DM_LAST_DEF = 32'h6600_00FC;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract with sign/zero extension for loads, lane merge for sub-word stores
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        uns,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;
    logic [31:0] ins;

    assign b       = rd[{lane, 3'b000} +: 8];
    assign h       = rd[{lane[1], 4'b0000} +: 16];
    assign ld_data = size == SZ_BYTE ? {{24{b[7] & ~uns}}, b} :
                     size == SZ_HALF ? {{16{h[15] & ~uns}}, h} : rd;

    // replicate the store data across all lanes, then keep only the target lane
    assign mask    = size == SZ_BYTE ? 32'h0000_00FF << {lane, 3'b000} :
                     size == SZ_HALF ? 32'h0000_FFFF << {lane[1], 4'b0000} : '1;
    assign ins     = size == SZ_BYTE ? {4{wdata[7:0]}} :
                     size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    assign st_data = (rd & ~mask) | (ins & mask);

endmodule

// File: rtl/lsu.sv
// lsu: word-only data-memory initiator with RMW sub-word stores; LSU_RANGE_CHECK_EN enables the window check
module lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] DM_BASE = DM_BASE_DEF,
    parameter logic [31:0] DM_LAST = DM_LAST_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wd_o,
    output logic        dm_we_o,
    input  logic [31:0] dm_rd_i
);

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    size_e       size_q;
    logic [1:0]  lane_q;
    logic        uns_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] dm_addr_q;
    logic [31:0] dm_wd_q;
    logic [31:0] word_addr;
    logic        bad_align;
    logic        out_win;
    logic        req_err;
    logic        accept;
    logic [31:0] ld_data;
    logic [31:0] st_data;

    assign word_addr = {req_addr_i[31:2], 2'b00};
    assign bad_align = req_size_i == SZ_RSVD ||
                       (req_size_i == SZ_HALF && req_addr_i[0]) ||
                       (req_size_i == SZ_WORD && |req_addr_i[1:0]);
    assign out_win   = word_addr < DM_BASE || word_addr > DM_LAST;
    assign req_err   = bad_align || (RANGE_EN && out_win);
    assign accept    = state_q == IDLE && req_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          if (req_valid_i)
                               state_d = req_err                 ? RESP  :
                                         !req_we_i               ? LOAD  :
                                         req_size_i == SZ_WORD   ? STORE : RMW_RD;
            LOAD, STORE:   state_d = RESP;
            RMW_RD:        state_d = RMW_WR;
            RMW_WR:        state_d = RESP;
            RESP:          if (resp_ready_i) state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    // the DM address only moves for accesses that will really touch memory
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            size_q    <= SZ_BYTE;
            lane_q    <= '0;
            uns_q     <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            dm_addr_q <= '0;
            dm_wd_q   <= '0;
        end else begin
            if (accept) begin
                size_q  <= size_e'(req_size_i);
                lane_q  <= req_addr_i[1:0];
                uns_q   <= req_unsigned_i;
                rdata_q <= '0;
                err_q   <= req_err;
                if (!req_err) dm_addr_q <= word_addr;
                if (!req_err && req_we_i) dm_wd_q <= req_wdata_i;
            end
            if (state_q == LOAD) rdata_q <= ld_data;
            if (state_q == RMW_RD) dm_wd_q <= st_data;
        end
    end

    lsu_align u_align (
        .rd      (dm_rd_i),
        .wdata   (dm_wd_q),
        .lane    (lane_q),
        .size    (size_q),
        .uns     (uns_q),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    assign req_ready_o  = state_q == IDLE;
    assign resp_valid_o = state_q == RESP;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign dm_addr_o    = dm_addr_q;
    assign dm_wd_o      = dm_wd_q;
    assign dm_we_o      = (state_q == STORE || state_q == RMW_WR) && !rst_i;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized and directed checks of lsu against a transaction-level memory model
module tb_lsu;

    localparam logic [31:0] BASE = 32'h6600_0000;
    localparam logic [31:0] LAST = 32'h6600_00FC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic        dm_we;
    logic [31:0] dm_rd;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;

    lsu dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .dm_addr_o      (dm_addr),
        .dm_wd_o        (dm_wd),
        .dm_we_o        (dm_we),
        .dm_rd_i        (dm_rd)
    );

    assign dm_rd = mem[dm_addr[7:2]];

    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_addr[7:2]] <= dm_wd;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] w, input int lane, input int sz, input bit uns);
        logic [31:0] v;
        if (sz == 2) return w;
        if (sz == 0) begin
            v = (w >> (8 * lane)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = (w >> (16 * (lane / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input int lane, input int sz, input logic [31:0] d);
        int          sh;
        logic [31:0] m;
        if (sz == 2) return d;
        sh = sz == 0 ? 8 * lane : 16 * (lane / 2);
        m  = sz == 0 ? 32'hFF : 32'hFFFF;
        return w - (((w >> sh) & m) << sh) + ((d & m) << sh);
    endfunction

    task automatic txn(input bit we, input int sz, input bit uns, input logic [31:0] a,
                       input logic [31:0] wd, input int hold);
        logic [31:0] wa;
        int          lane, lat, wc, w0, idx;
        bit          err;
        logic [31:0] er, ew;
        wa   = {a[31:2], 2'b00};
        idx  = int'(a[7:2]);
        lane = int'(a[1:0]);
        err  = sz == 3 || (sz == 1 && lane % 2 != 0) || (sz == 2 && lane != 0);
`ifdef LSU_RANGE_CHECK_EN
        if (wa < BASE || wa > LAST) err = 1'b1;
`endif
        er = '0; ew = '0; wc = 0;
        if (err) lat = 1;
        else if (!we) begin
            lat = 2;
            er  = m_load(ref_mem[idx], lane, sz, uns);
        end else begin
            lat = sz == 2 ? 2 : 3;
            wc  = lat - 1;
            ew  = m_merge(ref_mem[idx], lane, sz, wd);
            ref_mem[idx] = ew;
        end
        @(negedge clk);
        chk("idle_ready", req_ready, 1);
        chk("idle_valid", resp_valid, 0);
        req_valid = 1'b1; req_we = we; req_size = 2'(sz); req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        w0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= lat + hold; k++) begin
            @(negedge clk);
            chk("busy_ready", req_ready, 0);
            chk("resp_valid", resp_valid, k >= lat);
            chk("dm_we", dm_we, k == wc);
            if (k == wc) begin
                chk("wr_addr", dm_addr, wa);
                chk("wr_data", dm_wd, ew);
            end
            if (!err && !we && k == 1) chk("ld_addr", dm_addr, wa);
            if (k >= lat) begin
                chk("rdata", resp_rdata, er);
                chk("err", resp_err, err);
            end
        end
        last_rdata = resp_rdata;
        last_err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("wr_count", wr_cnt - w0, wc != 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, req_ready, 1);
        chk({tag, "_valid"}, resp_valid, 0);
        chk({tag, "_rdata"}, resp_rdata, 0);
        chk({tag, "_err"}, resp_err, 0);
        chk({tag, "_addr"}, dm_addr, 0);
        chk({tag, "_wd"}, dm_wd, 0);
        chk({tag, "_we"}, dm_we, 0);
    endtask

    task automatic rst_mid(input logic [31:0] a, input logic [31:0] wd, input int at_k);
        int w0, idx;
        idx = int'(a[7:2]);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = a; req_wdata = wd;
        w0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (at_k) @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_we_gate", dm_we, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_mid");
        chk("rst_no_write", wr_cnt - w0, 0);
        chk("rst_mem", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8001_7F02; ref_mem[4] = 32'h8001_7F02;
        mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;

        chk("pin_lb", m_load(32'h8001_7F02, 3, 0, 0), 32'hFFFF_FF80);
        chk("pin_lh", m_load(32'h8001_7F02, 2, 1, 0), 32'hFFFF_8001);
        chk("pin_sb", m_merge(32'h1122_3344, 1, 0, 32'hAA), 32'h1122_AA44);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        txn(0, 2, 0, 32'h6600_0010, 0, 0);
        chk("lw_lit", last_rdata, 32'h8001_7F02);
        txn(0, 0, 0, 32'h6600_0013, 0, 0);
        chk("lb_lit", last_rdata, 32'hFFFF_FF80);
        txn(0, 0, 1, 32'h6600_0013, 0, 0);
        chk("lbu_lit", last_rdata, 32'h0000_0080);
        txn(0, 1, 0, 32'h6600_0012, 0, 0);
        chk("lh_lit", last_rdata, 32'hFFFF_8001);
        txn(1, 0, 0, 32'h6600_0021, 32'h0000_00AA, 0);
        chk("sb_lit", mem[8], 32'h1122_AA44);
        txn(0, 2, 0, 32'h6600_0006, 0, 0);
        chk("mis_err_lit", last_err, 1);
        txn(0, 3, 0, 32'h6600_0010, 0, 0);
        chk("rsvd_err_lit", last_err, 1);
`ifdef LSU_RANGE_CHECK_EN
        txn(1, 2, 0, 32'h6600_0100, 32'hDEAD_BEEF, 0);
        chk("win_err_lit", last_err, 1);
`endif
        txn(0, 2, 0, 32'h6600_0010, 0, 5);
        txn(1, 1, 0, 32'h6600_0032, 32'h0000_BEEF, 2);

        rst_mid(32'h6600_0031, 32'h55, 1);
        rst_mid(32'h6600_0032, 32'h77, 2);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = $urandom_range(0, 7) == 0 ? 32'($urandom) : BASE + 32'($urandom_range(0, 255));
            txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, 32'($urandom), int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
